alu_op_sequencer: RTL and testbench

- Upstream control stage for the 4-bit ALU.
- Buffers incoming ALU commands (opcode + two operands) in a small FIFO and issues them one at a time.
- For each issued command it drives the 3-to-8 operation decoder's enable/select inputs and the ALU operand buses, samples the ALU result, and returns it on a valid/ready response port.
- Serialises bursty command traffic and gives the combinational ALU a defined settle window.

---
 rtl/alu_op_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands in a FIFO and issues them one
// at a time to the op decoder / ALU, returning results on a rsp port.
module alu_op_sequencer #(
    parameter int DEPTH         = 4,
    parameter int PTR_W         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic             dec_enable,
    output logic [2:0]       dec_select,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_op,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic [PTR_W:0]   fifo_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_e;

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_CNT    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE     = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    state_e           state_q, state_d;
    logic [10:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [3:0]       settle_q, settle_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       rsp_op_q, rsp_op_d;
    logic [3:0]       rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;

    logic             push;
    logic             pop;
    logic             rsp_fire;
    logic             settle_done;
    logic [10:0]      head;

    // Full is decoded from registered count only: no bypass on a same-cycle pop.
    assign cmd_ready   = (count_q != FULL_CNT);
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state_q == IDLE) && (count_q != '0);
    assign head        = mem_q[rd_ptr_q];
    assign rsp_fire    = rsp_valid_q && rsp_ready;
    assign settle_done = (state_q == ISSUE) && (settle_q == '0);

    assign rsp_valid  = rsp_valid_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop)         state_d = ISSUE;
            ISSUE:   if (settle_done) state_d = RESPOND;
            RESPOND: if (rsp_fire)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, settle countdown and response capture.
    always_comb begin
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        settle_d     = settle_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_op_d     = rsp_op_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        if (pop) begin
            {op_d, a_d, b_d} = head;
            settle_d         = SETTLE_INIT;
        end else if ((state_q == ISSUE) && (settle_q != '0)) begin
            settle_d = settle_q - 4'd1;
        end
        if (settle_done) begin
            rsp_valid_d  = 1'b1;
            rsp_op_d     = op_q;
            rsp_result_d = alu_result;
            rsp_carry_d  = alu_carry;
        end else if (rsp_fire) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Decoder and operand buses are driven only while issuing.
    always_comb begin
        dec_enable = 1'b0;
        dec_select = '0;
        alu_a      = '0;
        alu_b      = '0;
        if (state_q == ISSUE) begin
            dec_enable = 1'b1;
            dec_select = op_q;
            alu_a      = a_q;
            alu_b      = b_q;
        end
    end

    // State register; reset drops everything queued or in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            settle_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            settle_q     <= settle_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_op_q     <= rsp_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + randomized checks of the sequencer
// against a queue-based reference model and a behavioural ALU.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic       dec_enable;
    logic [2:0] dec_select;
    logic [3:0] alu_a, alu_b, alu_result;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready;
    logic [2:0] rsp_op;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic [2:0] fifo_count;
    logic       busy;

    logic       c3_valid, c3_ready;
    logic [2:0] c3_op;
    logic [3:0] c3_a, c3_b;
    logic       en3;
    logic [2:0] sel3;
    logic [3:0] a3, b3, res3;
    logic       carry3;
    logic       rv3, rr3;
    logic [2:0] rop3;
    logic [3:0] rres3;
    logic       rcar3;
    logic [2:0] cnt3;
    logic       busy3;
    logic [3:0] pert3;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rsp   = 0;
    logic mon_en = 1'b0;
    logic [10:0] exp_q[$];
    logic prev_hold = 1'b0;
    logic [8:0] prev_rsp = '0;

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_f(input logic [2:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {|(a & b), a ^ b};
            3'd4:    return {1'b0, a | b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a[3], a[2:0], 1'b0};
            default: return {a[0], 1'b0, a[3:1]};
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_f(dec_select, alu_a, alu_b);
    assign {carry3, res3} = alu_f(sel3, a3, b3) ^ {1'b0, pert3};

    alu_op_sequencer #(.DEPTH(4), .PTR_W(2), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .dec_enable(dec_enable), .dec_select(dec_select),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_op(rsp_op), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .fifo_count(fifo_count), .busy(busy)
    );

    alu_op_sequencer #(.DEPTH(4), .PTR_W(2), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_op(c3_op), .cmd_a(c3_a), .cmd_b(c3_b),
        .dec_enable(en3), .dec_select(sel3),
        .alu_a(a3), .alu_b(b3),
        .alu_result(res3), .alu_carry(carry3),
        .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_op(rop3), .rsp_result(rres3), .rsp_carry(rcar3),
        .fifo_count(cnt3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cmd();
        cmd_op = 3'($urandom_range(0, 7));
        cmd_a  = 4'($urandom_range(0, 15));
        cmd_b  = 4'($urandom_range(0, 15));
    endtask

    // Reference model: accepted commands queue up, the head is the one
    // on the ALU buses, and each handshake retires it in order.
    always @(negedge clk) begin
        logic [10:0] e;
        if (mon_en && !rst) begin
            if (!dec_enable) begin
                chk("idle_sel", 32'(dec_select), 0);
                chk("idle_ab", 32'({alu_a, alu_b}), 0);
            end else if (exp_q.size() == 0) begin
                chk("issue_unexp", 32'(dec_enable), 0);
            end else begin
                chk("issue_ops", 32'({dec_select, alu_a, alu_b}), 32'(exp_q[0]));
            end
            if (rsp_valid) chk("rsp_vs_en", 32'(dec_enable), 0);
            if (prev_hold)
                chk("rsp_stable",
                    32'({rsp_valid, rsp_op, rsp_carry, rsp_result}),
                    32'(prev_rsp));
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_valid, rsp_op, rsp_carry, rsp_result};
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexp", 32'(rsp_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_op", 32'(rsp_op), 32'(e[10:8]));
                    chk("rsp_res", 32'({rsp_carry, rsp_result}),
                        32'(alu_f(e[10:8], e[7:4], e[3:0])));
                end
                n_rsp++;
            end
            if (cmd_valid && cmd_ready)
                exp_q.push_back({cmd_op, cmd_a, cmd_b});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int sent;
        int t;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b0;
        c3_valid = 1'b0; c3_op = '0; c3_a = '0; c3_b = '0;
        rr3 = 1'b0; pert3 = '0;
        step();
        step();
        chk("rst_en", 32'(dec_enable), 0);
        chk("rst_sel_ab", 32'({dec_select, alu_a, alu_b}), 0);
        chk("rst_rsp", 32'({rsp_valid, rsp_op, rsp_result, rsp_carry}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(fifo_count), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        mon_en = 1'b1;

        // single command, SETTLE_CYCLES=1
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 4'd5; cmd_b = 4'd9;
        step();
        cmd_valid = 1'b0;
        chk("c1_en", 32'(dec_enable), 0);
        chk("c1_cnt", 32'(fifo_count), 1);
        step();
        chk("c2_en", 32'(dec_enable), 1);
        chk("c2_ops", 32'({dec_select, alu_a, alu_b}), 32'({3'd3, 4'd5, 4'd9}));
        step();
        chk("c3_en", 32'(dec_enable), 0);
        chk("c3_rv", 32'(rsp_valid), 1);
        chk("c3_rsp", 32'({rsp_op, rsp_result, rsp_carry}),
            32'({3'd3, 4'hC, 1'b1}));

        // backpressure with a second command waiting
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 4'd2; cmd_b = 4'd7;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("bp_rv", 32'(rsp_valid), 1);
            chk("bp_en", 32'(dec_enable), 0);
            chk("bp_cnt", 32'(fifo_count), 1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("hs_rv", 32'(rsp_valid), 0);
        chk("hs_en", 32'(dec_enable), 0);
        step();
        chk("hs_issue", 32'({dec_enable, dec_select}), 32'({1'b1, 3'd1}));
        t = 0;
        while (busy && t < 50) begin step(); t++; end
        chk("drain1", 32'(busy), 0);

        // FIFO full with responses stalled
        rsp_ready = 1'b0;
        base = n_rsp;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            rand_cmd();
            if (i == 5) begin
                chk("full_ready", 32'(cmd_ready), 0);
                chk("full_cnt", 32'(fifo_count), 4);
            end
            step();
        end
        cmd_valid = 1'b0;
        chk("full_cnt2", 32'(fifo_count), 4);
        chk("full_ready2", 32'(cmd_ready), 0);
        chk("full_busy", 32'(busy), 1);
        rsp_ready = 1'b1;
        t = 0;
        while (busy && t < 100) begin step(); t++; end
        chk("full_rsp_n", 32'(n_rsp - base), 5);
        chk("full_left", 32'(exp_q.size()), 0);

        // wrap-around with random stalls
        base = n_rsp;
        sent = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (sent == 20 && (n_rsp - base) == 20) break;
            rsp_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                cmd_valid = 1'($urandom_range(0, 1));
                rand_cmd();
            end else begin
                cmd_valid = 1'b0;
            end
            if (cmd_valid && cmd_ready) sent++;
            step();
        end
        cmd_valid = 1'b0;
        chk("wrap_sent", 32'(sent), 20);
        chk("wrap_rsp_n", 32'(n_rsp - base), 20);
        chk("wrap_left", 32'(exp_q.size()), 0);

        // reset during ISSUE with 3 commands queued
        rsp_ready = 1'b0;
        t = 0;
        while (busy && t < 20) begin rsp_ready = 1'b1; step(); t++; end
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; rand_cmd();
        step();
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin step(); t++; end
        chk("mr_rv", 32'(rsp_valid), 1);
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; rand_cmd();
            step();
        end
        cmd_valid = 1'b0;
        chk("mr_cnt4", 32'(fifo_count), 4);
        rsp_ready = 1'b1;
        step();
        step();
        chk("mr_issue", 32'(dec_enable), 1);
        chk("mr_cnt3", 32'(fifo_count), 3);
        rst = 1'b1;
        step();
        exp_q.delete();
        prev_hold = 1'b0;
        chk("mr_en", 32'(dec_enable), 0);
        chk("mr_rv0", 32'(rsp_valid), 0);
        chk("mr_cnt0", 32'(fifo_count), 0);
        chk("mr_busy", 32'(busy), 0);
        rst = 1'b0;
        base = n_rsp;
        repeat (20) step();
        chk("mr_no_rsp", 32'(n_rsp - base), 0);

        // settle window on the SETTLE_CYCLES=3 instance
        pert3 = 4'hA;
        c3_valid = 1'b1; c3_op = 3'd0; c3_a = 4'd6; c3_b = 4'd7;
        step();
        c3_valid = 1'b0;
        chk("s_c1_en", 32'(en3), 0);
        step();
        chk("s_c2_en", 32'(en3), 1);
        step();
        chk("s_c3_en", 32'(en3), 1);
        pert3 = 4'h0;
        step();
        chk("s_c4_en", 32'(en3), 1);
        chk("s_c4_rv", 32'(rv3), 0);
        step();
        chk("s_c5_en", 32'(en3), 0);
        chk("s_c5_rv", 32'(rv3), 1);
        chk("s_c5_rsp", 32'({rop3, rcar3, rres3}), 32'({3'd0, 1'b0, 4'hD}));
        rr3 = 1'b1;
        step();
        chk("s_hs_rv", 32'(rv3), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
